// File: rtl/dvfs_pkg.sv
// Shared types and constants for the DVFS clock controller: level type, FSM states,
// default opcode-to-level map and the opcodes the map singles out.
package dvfs_pkg;

   localparam int LVL_W_DEF = 2;

   typedef logic [LVL_W_DEF-1:0] level_t;

   typedef enum logic {
      RUN  = 1'b0,
      PEND = 1'b1
   } state_t;

   // Two bits per opcode: ADD->0, SUB->1, MUL->3, everything else->2
   localparam logic [15:0] DEFAULT_LEVEL_MAP = 16'hABA4;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_MUL = 3'd4;

endpackage

// File: rtl/dvfs_divider.sv
// Half-period counter producing the registered divided clock, its rising-edge strobe
// and the terminal-count flag the controller uses to time level switches.
module dvfs_divider #(
   parameter int LVL_W = 2,
   parameter int CNT_W = 3
) (
   input  logic             clk_in,
   input  logic             reset,
   input  logic [LVL_W-1:0] level,
   output logic             clk_out,
   output logic             clk_en,
   output logic             terminal
);

   logic [CNT_W-1:0] half_cnt;
   logic [CNT_W-1:0] half_max;

   always_comb begin
      half_max = CNT_W'((32'd1 << level) - 32'd1);
      terminal = (half_cnt == half_max);
   end

   // A level change only lands on a terminal count, so the counter is already
   // returning to zero and the next phase starts cleanly at the new length.
   always_ff @(posedge clk_in) begin
      if (reset) begin
         half_cnt <= '0;
         clk_out  <= 1'b0;
         clk_en   <= 1'b0;
      end else if (terminal) begin
         half_cnt <= '0;
         clk_out  <= ~clk_out;
         clk_en   <= ~clk_out;
      end else begin
         half_cnt <= half_cnt + CNT_W'(1);
         clk_en   <= 1'b0;
      end
   end

endmodule

// File: rtl/dvfs_clock_ctrl.sv
// DVFS clock generator: maps opcodes (or a forced level) to a target divider level and
// applies it glitch-free at a clk_out falling boundary once the dwell time has expired.
module dvfs_clock_ctrl
   import dvfs_pkg::*;
#(
   parameter int                                NUM_LEVELS  = 4,
   parameter int                                LVL_W       = 2,
   parameter int                                OPCODE_W    = 3,
   parameter logic [LVL_W*(2**OPCODE_W)-1:0]   LEVEL_MAP   = DEFAULT_LEVEL_MAP,
   parameter int                                MIN_DWELL   = 16,
   parameter int                                RESET_LEVEL = 0
) (
   input  logic                clk_in,
   input  logic                reset,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                op_valid,
   input  logic                force_en,
   input  logic [LVL_W-1:0]    force_level,
   output logic                clk_out,
   output logic                clk_en,
   output logic [LVL_W-1:0]    cur_level,
   output logic                switch_pending,
   output logic                switch_done
);

   localparam int CNT_W   = (NUM_LEVELS > 1) ? NUM_LEVELS - 1 : 1;
   localparam int DWELL_W = $clog2(MIN_DWELL + 1);

   state_t             state;
   state_t             state_next;
   logic [LVL_W-1:0]   tgt;
   logic [LVL_W-1:0]   tgt_next;
   logic [LVL_W-1:0]   map_lvl;
   logic [DWELL_W-1:0] dwell;
   logic               terminal;
   logic               do_switch;

   function automatic logic [LVL_W-1:0] clampLevel(input logic [LVL_W-1:0] lvl);
      if (32'(lvl) >= 32'(NUM_LEVELS)) begin
         return LVL_W'(NUM_LEVELS - 1);
      end
      return lvl;
   endfunction

   dvfs_divider #(
      .LVL_W (LVL_W),
      .CNT_W (CNT_W)
   ) u_divider (
      .clk_in   (clk_in),
      .reset    (reset),
      .level    (cur_level),
      .clk_out  (clk_out),
      .clk_en   (clk_en),
      .terminal (terminal)
   );

   always_comb begin
      map_lvl = '0;
      for (int i = 0; i < 2**OPCODE_W; i++) begin
         if (opcode == OPCODE_W'(i)) begin
            map_lvl = LEVEL_MAP[LVL_W*i +: LVL_W];
         end
      end
   end

   // Latest request wins; a forced level overrides whatever the decoder says.
   always_comb begin
      tgt_next = tgt;
      if (force_en) begin
         tgt_next = clampLevel(force_level);
      end else if (op_valid) begin
         tgt_next = clampLevel(map_lvl);
      end
   end

   always_comb begin
      state_next = state;
      do_switch  = 1'b0;
      case (state)
         RUN: begin
            if (tgt != cur_level) begin
               state_next = PEND;
            end
         end
         PEND: begin
            if (tgt == cur_level) begin
               state_next = RUN;
            end else if (clk_out && terminal && (dwell == '0)) begin
               do_switch  = 1'b1;
               state_next = RUN;
            end
         end
         default: state_next = RUN;
      endcase
   end

   assign switch_pending = (state == PEND);

   // cur_level takes the target held before this edge, so a request arriving in the
   // switch cycle is left in tgt and re-enters PEND afterwards.
   always_ff @(posedge clk_in) begin
      if (reset) begin
         state       <= RUN;
         tgt         <= LVL_W'(RESET_LEVEL);
         cur_level   <= LVL_W'(RESET_LEVEL);
         dwell       <= '0;
         switch_done <= 1'b0;
      end else begin
         state       <= state_next;
         tgt         <= tgt_next;
         switch_done <= do_switch;
         if (do_switch) begin
            cur_level <= tgt;
            dwell     <= DWELL_W'(MIN_DWELL);
         end else if (dwell != '0) begin
            dwell <= dwell - DWELL_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_dvfs_clock_ctrl.sv
// Self-checking bench for dvfs_clock_ctrl: a cycle-level behavioural model checked every
// cycle, a clk_out phase-length checker, and directed scenarios with literal expectations.
module tb_dvfs_clock_ctrl;
   import dvfs_pkg::*;

   logic       clk_in = 1'b0;
   logic       reset = 1'b1;
   logic [2:0] opcode = 3'd0;
   logic       op_valid = 1'b0;
   logic       force_en = 1'b0;
   logic [1:0] force_level = 2'd0;
   logic       clk_out;
   logic       clk_en;
   logic [1:0] cur_level;
   logic       switch_pending;
   logic       switch_done;

   int assertions = 0;
   int failures = 0;

   dvfs_clock_ctrl dut (
      .clk_in         (clk_in),
      .reset          (reset),
      .opcode         (opcode),
      .op_valid       (op_valid),
      .force_en       (force_en),
      .force_level    (force_level),
      .clk_out        (clk_out),
      .clk_en         (clk_en),
      .cur_level      (cur_level),
      .switch_pending (switch_pending),
      .switch_done    (switch_done)
   );

   always #5 clk_in = ~clk_in;

   task automatic checkOutput(input string name, input int actual, input int expected);
      assertions++;
      if (actual != expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic checkAtLeast(input string name, input int actual, input int minimum);
      assertions++;
      if (actual < minimum) begin
         failures++;
         $display("[TB] FAIL %s: got %0d, expected at least %0d at %0t", name, actual, minimum, $time);
      end
   endtask

   // Specification-level opcode map: ADD->0, SUB->1, MUL->3, anything else->2
   function automatic int expectedLevel(input logic [2:0] op);
      case (op)
         OP_ADD:  return 0;
         OP_SUB:  return 1;
         OP_MUL:  return 3;
         default: return 2;
      endcase
   endfunction

   function automatic int clampTb(input logic [1:0] lvl);
      return (int'(lvl) >= 4) ? 3 : int'(lvl);
   endfunction

   // Behavioural model: each clk_out phase lasts 2^level cycles; a level change happens
   // only at the end of a high phase, once the dwell has run out.
   bit m_valid = 0;
   bit m_just_reset = 0;
   int m_level, m_tgt, m_dwell, m_phase_age;
   bit m_clk, m_clk_en, m_pending, m_done;

   always @(posedge clk_in) begin
      int  req;
      bit  phaseEnds;
      bit  switching;
      if (reset) begin
         m_valid      = 1;
         m_just_reset = 1;
         m_level      = 0;
         m_tgt        = 0;
         m_dwell      = 0;
         m_phase_age  = 0;
         m_clk        = 0;
         m_clk_en     = 0;
         m_pending    = 0;
         m_done       = 0;
      end else if (m_valid) begin
         m_just_reset = 0;
         phaseEnds = (m_phase_age + 1 >= (1 << m_level));
         switching = m_pending && (m_tgt != m_level) && m_clk && phaseEnds && (m_dwell == 0);
         req = m_tgt;
         if (force_en) req = clampTb(force_level);
         else if (op_valid) req = expectedLevel(opcode);
         m_done    = switching;
         m_pending = switching ? 1'b0 : (m_tgt != m_level);
         m_clk_en  = phaseEnds && !m_clk;
         if (phaseEnds) begin
            m_clk       = !m_clk;
            m_phase_age = 0;
         end else begin
            m_phase_age++;
         end
         if (switching) begin
            m_level = m_tgt;
            m_dwell = 16;
         end else if (m_dwell > 0) begin
            m_dwell--;
         end
         m_tgt = req;
      end
   end

   // Per-cycle comparison against the model, plus the minimum phase-length rule.
   logic prevClk;
   int   phaseLen = 0;
   int   phaseLevel = 0;

   always @(negedge clk_in) begin
      int minLvl;
      if (m_valid) begin
         checkOutput("clk_out", int'(clk_out), int'(m_clk));
         checkOutput("clk_en", int'(clk_en), int'(m_clk_en));
         checkOutput("cur_level", int'(cur_level), m_level);
         checkOutput("switch_pending", int'(switch_pending), int'(m_pending));
         checkOutput("switch_done", int'(switch_done), int'(m_done));
         if (m_just_reset) begin
            prevClk    = clk_out;
            phaseLen   = 1;
            phaseLevel = m_level;
         end else if (clk_out === prevClk) begin
            phaseLen++;
         end else begin
            minLvl = (phaseLevel < m_level) ? phaseLevel : m_level;
            checkAtLeast("phase_len", phaseLen, 1 << minLvl);
            prevClk    = clk_out;
            phaseLen   = 1;
            phaseLevel = m_level;
         end
      end
   end

   task automatic tick();
      @(negedge clk_in);
   endtask

   task automatic applyStimulus(input logic [2:0] op, input logic valid,
                                input logic fen, input logic [1:0] flevel);
      opcode      = op;
      op_valid    = valid;
      force_en    = fen;
      force_level = flevel;
   endtask

   task automatic waitSwitchDone(input int budget, output int cycles);
      cycles = 0;
      while (!switch_done && cycles < budget) begin
         tick();
         cycles++;
      end
      if (!switch_done) checkOutput("switch_done_timeout", 0, 1);
   endtask

   task automatic measurePeriod(output int period);
      int n = 0;
      do begin
         tick();
         n++;
      end while (!clk_en && n < 64);
      period = 0;
      do begin
         tick();
         period++;
      end while (!clk_en && period < 64);
   endtask

   task automatic countDone(input int cycles, output int pulses, output int pendSeen);
      pulses   = 0;
      pendSeen = 0;
      for (int i = 0; i < cycles; i++) begin
         tick();
         if (switch_done) pulses++;
         if (switch_pending) pendSeen++;
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int period, cycles, total, pulses, pendSeen;

      // Scenario 1: one reset cycle with ADD valid, level 0 runs at clk_in/2
      applyStimulus(OP_ADD, 1'b1, 1'b0, 2'd0);
      tick();
      reset = 1'b0;
      checkOutput("reset_clk_out", int'(clk_out), 0);
      checkOutput("reset_clk_en", int'(clk_en), 0);
      checkOutput("reset_cur_level", int'(cur_level), 0);
      checkOutput("reset_pending", int'(switch_pending), 0);
      checkOutput("reset_done", int'(switch_done), 0);
      tick();
      applyStimulus(OP_ADD, 1'b0, 1'b0, 2'd0);
      measurePeriod(period);
      checkOutput("period_level0", period, 2);

      // Scenario 2: MUL request, switch at the next fall, period becomes 16
      applyStimulus(OP_MUL, 1'b1, 1'b0, 2'd0);
      tick();
      applyStimulus(OP_ADD, 1'b0, 1'b0, 2'd0);
      tick();
      checkOutput("mul_pending", int'(switch_pending), 1);
      waitSwitchDone(24, cycles);
      checkOutput("mul_level", int'(cur_level), 3);
      measurePeriod(period);
      checkOutput("period_level3", period, 16);

      // Scenario 3: drop to level 0, then ask for SUB three cycles after that switch
      applyStimulus(OP_ADD, 1'b1, 1'b0, 2'd0);
      tick();
      applyStimulus(OP_ADD, 1'b0, 1'b0, 2'd0);
      waitSwitchDone(40, cycles);
      checkOutput("add_level", int'(cur_level), 0);
      tick();
      tick();
      applyStimulus(OP_SUB, 1'b1, 1'b0, 2'd0);
      tick();
      applyStimulus(OP_ADD, 1'b0, 1'b0, 2'd0);
      waitSwitchDone(40, cycles);
      total = cycles + 3;
      checkAtLeast("dwell_spacing", total, 16);
      checkOutput("sub_level", int'(cur_level), 1);
      measurePeriod(period);
      checkOutput("period_level1", period, 4);

      // Scenario 4: request level 2 then back to the current level before the switch
      applyStimulus(3'd2, 1'b1, 1'b0, 2'd0);
      tick();
      applyStimulus(OP_SUB, 1'b1, 1'b0, 2'd0);
      tick();
      applyStimulus(OP_ADD, 1'b0, 1'b0, 2'd0);
      checkOutput("cancel_pending_seen", int'(switch_pending), 1);
      countDone(20, pulses, pendSeen);
      checkOutput("cancel_no_done", pulses, 0);
      checkOutput("cancel_pending_cycles", pendSeen, 0);
      checkOutput("cancel_level", int'(cur_level), 1);
      measurePeriod(period);
      checkOutput("period_after_cancel", period, 4);

      // Scenario 5: force level 3 while ADD is valid; level then holds with no requests
      applyStimulus(OP_ADD, 1'b1, 1'b1, 2'd3);
      tick();
      applyStimulus(OP_ADD, 1'b0, 1'b0, 2'd0);
      waitSwitchDone(40, cycles);
      checkOutput("force_level", int'(cur_level), 3);
      countDone(40, pulses, pendSeen);
      checkOutput("force_hold_done", pulses, 0);
      checkOutput("force_hold_level", int'(cur_level), 3);

      // Scenario 6: reset while a switch to level 0 is pending
      applyStimulus(OP_ADD, 1'b1, 1'b0, 2'd0);
      tick();
      applyStimulus(OP_ADD, 1'b0, 1'b0, 2'd0);
      tick();
      checkOutput("pre_reset_pending", int'(switch_pending), 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checkOutput("midreset_clk_out", int'(clk_out), 0);
      checkOutput("midreset_level", int'(cur_level), 0);
      checkOutput("midreset_done", int'(switch_done), 0);
      checkOutput("midreset_pending", int'(switch_pending), 0);
      countDone(20, pulses, pendSeen);
      checkOutput("post_reset_done", pulses, 0);
      checkOutput("post_reset_pending", pendSeen, 0);
      measurePeriod(period);
      checkOutput("period_post_reset", period, 2);

      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end

endmodule
